// File: rtl/zeroheti_apb_timer.sv
// APB completer for a 64-bit machine timer with prescaler, compare and level interrupt.
// Access phase runs through IDLE/WAIT/RESP; register writes commit in the RESP cycle.
//
// state | meaning
// IDLE  | no access in progress; waiting for psel_i & penable_i
// WAIT  | access phase, pready_o=0 while wait states count down
// RESP  | pready_o=1 for one cycle; write commits, read data presented
module zeroheti_apb_timer #(
  parameter int unsigned CntWidth      = 64,
  parameter int unsigned PrescWidth    = 16,
  parameter int unsigned NumWaitStates = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  input  logic [2:0]  pprot_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        irq_o
);

  localparam int unsigned HiW = CntWidth - 32;
  localparam logic [1:0] WaitLoad = (NumWaitStates > 0) ? 2'(NumWaitStates - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    merge_bytes = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merge_bytes[8*i +: 8] = wdata[8*i +: 8];
    end
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            wcnt_q, wcnt_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  en_q, en_d, irq_en_q, irq_en_d;
  logic [PrescWidth-1:0] presc_q, presc_d, pc_q, pc_d;
  logic [CntWidth-1:0]   mtime_q, mtime_d, cmp_q, cmp_d;
  logic [HiW-1:0]        shadow_q, shadow_d;
  logic                  pending_q, pending_d, irq_q, irq_d;

  logic [2:0]  addr;
  logic        rd_sample, wr_commit, w1c, tick, hit;
  logic [31:0] rdata, presc_ext, mtime_hi_ext, cmp_hi_ext, shadow_ext;
  logic [31:0] wr_presc, wr_mtime_hi, wr_cmp_hi;
  logic        unused_ok;

  assign addr      = paddr_i[4:2];
  assign wr_commit = (state_q == RESP) & psel_i & pwrite_i;
  assign tick      = en_q & (pc_q == presc_q);
  assign hit       = en_q & (mtime_q >= cmp_q);
  assign unused_ok = ^{pprot_i, paddr_i[31:5], paddr_i[1:0], wr_presc, wr_mtime_hi, wr_cmp_hi};

  always_comb begin
    presc_ext    = '0;
    mtime_hi_ext = '0;
    cmp_hi_ext   = '0;
    shadow_ext   = '0;
    presc_ext[PrescWidth-1:0] = presc_q;
    mtime_hi_ext[HiW-1:0]     = mtime_q[CntWidth-1:32];
    cmp_hi_ext[HiW-1:0]       = cmp_q[CntWidth-1:32];
    shadow_ext[HiW-1:0]       = shadow_q;
  end

  assign wr_presc    = merge_bytes(presc_ext, pwdata_i, pstrb_i);
  assign wr_mtime_hi = merge_bytes(mtime_hi_ext, pwdata_i, pstrb_i);
  assign wr_cmp_hi   = merge_bytes(cmp_hi_ext, pwdata_i, pstrb_i);

  always_comb begin
    rdata = '0;
    case (addr)
      3'd0: rdata[1:0] = {irq_en_q, en_q};
      3'd1: rdata = presc_ext;
      3'd2: rdata = mtime_q[31:0];
      3'd3: rdata = shadow_ext;
      3'd4: rdata = cmp_q[31:0];
      3'd5: rdata = cmp_hi_ext;
      3'd6: rdata[0] = pending_q;
      default: rdata = '0;
    endcase
  end

  // A dropped psel_i during WAIT abandons the transfer without a response.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rd_sample = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel_i & penable_i) begin
          if (NumWaitStates == 0) begin
            state_d   = RESP;
            rd_sample = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = WaitLoad;
          end
        end
      end
      WAIT: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (wcnt_q == 2'd0) begin
          state_d   = RESP;
          rd_sample = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prdata_d  = (rd_sample & ~pwrite_i & (addr != 3'd7)) ? rdata : '0;
    pslverr_d = rd_sample & (addr == 3'd7);
    shadow_d  = shadow_q;
    if (rd_sample & ~pwrite_i & (addr == 3'd2)) shadow_d = mtime_q[CntWidth-1:32];

    en_d     = en_q;
    irq_en_d = irq_en_q;
    presc_d  = presc_q;
    cmp_d    = cmp_q;
    w1c      = 1'b0;
    pc_d     = pc_q;
    mtime_d  = mtime_q;
    if (en_q) pc_d = tick ? '0 : pc_q + 1'b1;
    if (tick) mtime_d = mtime_q + 1'b1;

    // Software writes to the counter take priority over the tick increment.
    if (wr_commit) begin
      case (addr)
        3'd0: if (pstrb_i[0]) begin
          en_d     = pwdata_i[0];
          irq_en_d = pwdata_i[1];
        end
        3'd1: begin
          presc_d = wr_presc[PrescWidth-1:0];
          pc_d    = '0;
        end
        3'd2: begin
          mtime_d        = mtime_q;
          mtime_d[31:0]  = merge_bytes(mtime_q[31:0], pwdata_i, pstrb_i);
        end
        3'd3: begin
          mtime_d                 = mtime_q;
          mtime_d[CntWidth-1:32]  = wr_mtime_hi[HiW-1:0];
        end
        3'd4: cmp_d[31:0]          = merge_bytes(cmp_q[31:0], pwdata_i, pstrb_i);
        3'd5: cmp_d[CntWidth-1:32] = wr_cmp_hi[HiW-1:0];
        3'd6: w1c = pstrb_i[0] & pwdata_i[0];
        default: ;
      endcase
    end

    pending_d = hit | (pending_q & ~w1c);
    irq_d     = pending_q & irq_en_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      presc_q   <= '0;
      pc_q      <= '0;
      mtime_q   <= '0;
      cmp_q     <= '1;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      presc_q   <= presc_d;
      pc_q      <= pc_d;
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign pready_o  = (state_q == RESP);
  assign prdata_o  = prdata_q;
  assign pslverr_o = pslverr_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_zeroheti_apb_timer.sv
// Directed bench for zeroheti_apb_timer: APB timing, prescaler, 64-bit carry/wrap,
// compare/interrupt, error response, byte strobes, aborted transfer and async reset.
module tb_zeroheti_apb_timer;
  localparam int NWS = 1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i, pwdata_i;
  logic [3:0]  pstrb_i;
  logic [2:0]  pprot_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o, irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  zeroheti_apb_timer #(.CntWidth(64), .PrescWidth(16), .NumWaitStates(NWS)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .psel_i   (psel_i),
    .penable_i(penable_i),
    .pwrite_i (pwrite_i),
    .paddr_i  (paddr_i),
    .pwdata_i (pwdata_i),
    .pstrb_i  (pstrb_i),
    .pprot_i  (pprot_i),
    .prdata_o (prdata_o),
    .pready_o (pready_o),
    .pslverr_o(pslverr_o),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Entered and left at posedge+1; holds psel through the RESP cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    int lat;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = addr; pwdata_i = wdata; pstrb_i = strb;
    @(posedge clk_i); #1 penable_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!pready_o && lat < 10);
    rdata = prdata_o;
    err   = pslverr_o;
    check_val("xfer_latency", 64'(lat), 64'(2 + NWS));
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; pstrb_i = 4'h0;
  endtask

  task automatic apb_rd(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err,
                        input string tag);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b0, addr, 32'h0, 4'h0, rd, err);
    check_val(tag, {32'h0, rd}, {32'h0, exp});
    check_val({tag, "_err"}, {63'h0, err}, {63'h0, exp_err});
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic exp_err);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, addr, data, strb, rd, err);
    check_val("wr_err", {63'h0, err}, {63'h0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rst_exp [7];
    rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0; pprot_i = '0;

    #1;
    check_val("rst_pready", {63'h0, pready_o}, 64'h0);
    check_val("rst_prdata", {32'h0, prdata_o}, 64'h0);
    check_val("rst_pslverr", {63'h0, pslverr_o}, 64'h0);
    check_val("rst_irq", {63'h0, irq_o}, 64'h0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 7; i++) apb_rd(32'(i * 4), rst_exp[i], 1'b0, "rst_read");

    // Prescaler 3: one tick every 4 enabled cycles.
    apb_wr(32'h04, 32'd3, 4'hF, 1'b0);
    apb_wr(32'h00, 32'd1, 4'hF, 1'b0);
    repeat (40) @(posedge clk_i);
    #1;
    apb_rd(32'h08, 32'd10, 1'b0, "presc_mtime");
    apb_wr(32'h00, 32'd0, 4'hF, 1'b0);
    apb_rd(32'h08, 32'd12, 1'b0, "hold_mtime_a");
    apb_rd(32'h08, 32'd12, 1'b0, "hold_mtime_b");

    // Carry from LO into HI, coherent HI read via shadow.
    apb_wr(32'h0C, 32'h0, 4'hF, 1'b0);
    apb_wr(32'h08, 32'hFFFF_FFFE, 4'hF, 1'b0);
    apb_wr(32'h04, 32'h0, 4'hF, 1'b0);
    apb_wr(32'h00, 32'd1, 4'hF, 1'b0);
    apb_rd(32'h08, 32'h0, 1'b0, "carry_lo");
    apb_rd(32'h0C, 32'h1, 1'b0, "carry_hi");
    apb_wr(32'h00, 32'd0, 4'hF, 1'b0);

    // Full wrap; mtime equal to all-ones cmp raises pending.
    apb_wr(32'h08, 32'hFFFF_FFFF, 4'hF, 1'b0);
    apb_wr(32'h0C, 32'hFFFF_FFFF, 4'hF, 1'b0);
    apb_wr(32'h00, 32'd1, 4'hF, 1'b0);
    apb_rd(32'h08, 32'h1, 1'b0, "wrap_lo");
    apb_rd(32'h0C, 32'h0, 1'b0, "wrap_hi");
    apb_wr(32'h00, 32'd0, 4'hF, 1'b0);
    apb_rd(32'h18, 32'h1, 1'b0, "wrap_pending");
    apb_wr(32'h18, 32'h1, 4'hF, 1'b0);
    apb_rd(32'h18, 32'h0, 1'b0, "wrap_w1c");

    // Compare at 20, prescaler 0: mtime=20 after 20 cycles, irq two cycles later.
    apb_wr(32'h0C, 32'h0, 4'hF, 1'b0);
    apb_wr(32'h08, 32'h0, 4'hF, 1'b0);
    apb_wr(32'h14, 32'h0, 4'hF, 1'b0);
    apb_wr(32'h10, 32'd20, 4'hF, 1'b0);
    apb_wr(32'h00, 32'd3, 4'hF, 1'b0);
    for (int n = 0; n < 26; n++) begin
      @(negedge clk_i);
      check_val("irq_rise", {63'h0, irq_o}, {63'h0, (n >= 22)});
    end
    @(posedge clk_i); #1;
    apb_wr(32'h18, 32'h1, 4'hF, 1'b0);
    apb_rd(32'h18, 32'h1, 1'b0, "w1c_while_hit");
    check_val("irq_held", {63'h0, irq_o}, 64'h1);
    apb_wr(32'h10, 32'hFFFF_FFFF, 4'hF, 1'b0);
    apb_wr(32'h18, 32'h1, 4'hF, 1'b0);
    check_val("irq_lag_a", {63'h0, irq_o}, 64'h1);
    @(negedge clk_i);
    check_val("irq_lag_b", {63'h0, irq_o}, 64'h1);
    @(negedge clk_i);
    check_val("irq_fall", {63'h0, irq_o}, 64'h0);
    @(posedge clk_i); #1;
    apb_rd(32'h18, 32'h0, 1'b0, "pending_cleared");
    apb_wr(32'h00, 32'd0, 4'hF, 1'b0);

    // Unmapped offset, byte strobes, narrow PRESCALE.
    apb_rd(32'h1C, 32'h0, 1'b1, "unmapped_rd");
    apb_wr(32'h1C, 32'hFFFF_FFFF, 4'hF, 1'b1);
    apb_rd(32'h00, 32'h0, 1'b0, "unmapped_ctrl");
    apb_rd(32'h10, 32'hFFFF_FFFF, 1'b0, "unmapped_cmp");
    apb_rd(32'h04, 32'h0, 1'b0, "unmapped_presc");
    apb_wr(32'h00, 32'h0203, 4'b0010, 1'b0);
    apb_rd(32'h00, 32'h0, 1'b0, "ctrl_strb_b1");
    apb_wr(32'h00, 32'h0203, 4'b0001, 1'b0);
    apb_rd(32'h00, 32'h3, 1'b0, "ctrl_strb_b0");
    apb_wr(32'h00, 32'h0, 4'hF, 1'b0);
    apb_wr(32'h04, 32'h0001_2345, 4'hF, 1'b0);
    apb_rd(32'h04, 32'h2345, 1'b0, "presc_width");
    apb_wr(32'h04, 32'h0, 4'hF, 1'b0);

    // psel dropped during WAIT: no response, no write.
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
    paddr_i = 32'h10; pwdata_i = 32'd5; pstrb_i = 4'hF;
    @(posedge clk_i); #1 penable_i = 1'b1;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      check_val("abort_pready", {63'h0, pready_o}, 64'h0);
    end
    @(posedge clk_i); #1;
    apb_rd(32'h10, 32'hFFFF_FFFF, 1'b0, "abort_cmp");

    // Asynchronous reset in the middle of a response.
    apb_wr(32'h10, 32'h0, 4'hF, 1'b0);
    apb_wr(32'h00, 32'd3, 4'hF, 1'b0);
    repeat (4) @(posedge clk_i);
    #1;
    check_val("pre_rst_irq", {63'h0, irq_o}, 64'h1);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h00;
    @(posedge clk_i); #1 penable_i = 1'b1;
    for (int n = 0; n < 10 && !pready_o; n++) @(negedge clk_i);
    check_val("pre_rst_pready", {63'h0, pready_o}, 64'h1);
    check_val("pre_rst_prdata", {32'h0, prdata_o}, 64'h3);
    #2 rst_ni = 1'b0;
    #1;
    check_val("mid_rst_pready", {63'h0, pready_o}, 64'h0);
    check_val("mid_rst_prdata", {32'h0, prdata_o}, 64'h0);
    check_val("mid_rst_pslverr", {63'h0, pslverr_o}, 64'h0);
    check_val("mid_rst_irq", {63'h0, irq_o}, 64'h0);
    psel_i = 1'b0; penable_i = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    apb_rd(32'h00, 32'h0, 1'b0, "post_rst_ctrl");
    apb_rd(32'h10, 32'hFFFF_FFFF, 1'b0, "post_rst_cmp");
    apb_rd(32'h08, 32'h0, 1'b0, "post_rst_mtime");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
